// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one imem read per instruction, latches the word for decode.
// Latency: instr_valid rises on the edge sampling imem_ready; a step at edge N presents the new request in cycle N+1.
// Backpressure: waits in FETCH until imem_ready; step_pc is honoured only in HOLD and is ignored whenever stall=1.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        step_pc,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        step_miss,
    output logic        misaligned
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        step_ok;
    logic        capture;
    logic        advance;
    logic        miss_evt;
    logic        redirect;
    logic [31:0] raw_target;

    assign step_ok  = step_pc && !stall;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ready) state_nxt = HOLD;
            HOLD:    if (step_ok)    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Request is gated by reset_n so it drops the instant reset asserts.
    always_comb begin
        imem_req  = (state == FETCH) && reset_n;
        imem_addr = pc;
        capture   = (state == FETCH) && imem_ready;
        advance   = (state == HOLD) && step_ok;
        miss_evt  = (state == FETCH) && step_ok;
    end

    always_comb begin
        redirect   = jump || branch_taken;
        raw_target = pc_plus4;
        if (jump) begin
            raw_target = jump_target;
        end else if (branch_taken) begin
            raw_target = branch_target;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            step_miss   <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (advance) begin
                pc          <= {raw_target[31:2], 2'b00};
                instr_valid <= 1'b0;
                if (redirect && (raw_target[1:0] != 2'b00)) begin
                    misaligned <= 1'b1;
                end
            end
            if (miss_evt) begin
                step_miss <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stepping/redirects against a PC/fetch reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST = 32'h0000_0100;

    logic        clock;
    logic        reset_n;
    logic        step_pc;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        step_miss;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RST)) dut (
        .clock(clock), .reset_n(reset_n), .step_pc(step_pc), .stall(stall),
        .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .instr_valid(instr_valid), .step_miss(step_miss), .misaligned(misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents are a fixed function of address; 0x100 holds 0x2008_0005.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a - 32'h100) * 32'h9E37_79B1 + 32'h2008_0005;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: PC, whether the instruction for PC is held, sticky flags, expected fetch addresses.
    logic [31:0] m_pc;
    bit          m_have;
    bit          m_miss;
    bit          m_mis;
    bit          model_on = 1'b0;
    logic [31:0] exp_q[$];
    bit          pend = 1'b0;
    logic [31:0] pend_word;
    logic [31:0] tgt;
    bit          redir;
    bit          have0;

    always @(negedge clock) begin
        if (model_on) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
            chk("imem_req", {31'd0, imem_req}, {31'd0, !m_have});
            if (!m_have) chk("imem_addr", imem_addr, m_pc);
            chk("step_miss", {31'd0, step_miss}, {31'd0, m_miss});
            chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            have0 = m_have;
            if (step_pc && !stall && !have0) m_miss = 1'b1;
            if (!have0 && imem_ready) m_have = 1'b1;
            if (step_pc && !stall && have0) begin
                redir = 1'b1;
                if (jump) tgt = jump_target;
                else if (branch_taken) tgt = branch_target;
                else begin
                    tgt   = m_pc + 32'd4;
                    redir = 1'b0;
                end
                if (redir && tgt[1:0] != 2'b00) m_mis = 1'b1;
                m_pc   = tgt & 32'hFFFF_FFFC;
                m_have = 1'b0;
                exp_q.push_back(m_pc);
            end
        end
    end

    // Monitor: every accepted request must match the next expected fetch, and the word must be latched.
    logic [31:0] exp_a;
    always @(negedge clock) begin
        if (model_on) begin
            if (pend) begin
                chk("instr", instr, pend_word);
                pend = 1'b0;
            end
            if (imem_req && imem_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_fetch: addr %h accepted, none expected", imem_addr);
                end else begin
                    exp_a = exp_q.pop_front();
                    chk("fetch_addr", imem_addr, exp_a);
                    pend_word = mem_word(exp_a);
                    pend      = 1'b1;
                end
            end
        end
    end

    task automatic drive(input bit s, input bit st, input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bt, input bit r);
        @(posedge clock);
        #1;
        step_pc = s; stall = st; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt; imem_ready = r;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, r);
    endtask

    // One 4-cycle phase period with zero-wait memory.
    task automatic do_step(input bit j, input logic [31:0] jt, input bit b, input logic [31:0] bt);
        drive(1'b1, 1'b0, j, jt, b, bt, 1'b1);
        idle(3, 1'b1);
        @(negedge clock);
    endtask

    task automatic model_reset();
        m_pc = RST; m_have = 1'b0; m_miss = 1'b0; m_mis = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST);
        pend = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, RST);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_miss"}, {31'd0, step_miss}, 32'd0);
        chk({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    endtask

    logic [31:0] rjt;
    logic [31:0] rbt;

    initial begin
        reset_n = 1'b0; step_pc = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = 32'd0;
        branch_taken = 1'b0; branch_target = 32'd0; imem_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");

        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1; imem_ready = 1'b1;
        model_on = 1'b1;
        @(negedge clock);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);
        @(negedge clock);
        chk("first_instr", instr, 32'h2008_0005);
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_req_drop", {31'd0, imem_req}, 32'd0);

        for (int i = 1; i <= 4; i++) begin
            do_step(1'b0, 32'd0, 1'b0, 32'd0);
            chk("seq_pc", pc, 32'h100 + 32'(4 * i));
        end

        do_step(1'b1, 32'h400, 1'b1, 32'h200);
        chk("jump_prio_pc", pc, 32'h400);
        do_step(1'b0, 32'd0, 1'b1, 32'h203);
        chk("branch_pc", pc, 32'h200);
        chk("branch_misaligned", {31'd0, misaligned}, 32'd1);

        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle(2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        idle(1, 1'b0);
        @(negedge clock);
        chk("slow_pc", pc, 32'h204);
        chk("slow_miss", {31'd0, step_miss}, 32'd1);
        chk("slow_instr", instr, mem_word(32'h204));
        drive(1'b1, 1'b1, 1'b1, 32'h800, 1'b0, 32'd0, 1'b1);
        idle(1, 1'b1);
        @(negedge clock);
        chk("stall_pc", pc, 32'h204);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);

        do_step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clock);
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        idle(2, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            rjt = $urandom;
            rbt = $urandom;
            if ($urandom_range(0, 3) != 0) rjt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rbt[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rjt,
                  $urandom_range(0, 3) == 0, rbt, $urandom_range(0, 1) == 1);
        end

        idle(5, 1'b1);
        @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL fetch_drain: %0d expected requests never accepted, required 0", exp_q.size());
        end

        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        #2;
        model_on = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (2) @(posedge clock);
        model_reset();
        #1;
        reset_n = 1'b1; imem_ready = 1'b1;
        model_on = 1'b1;
        @(negedge clock);
        chk("rerun_req", {31'd0, imem_req}, 32'd1);
        chk("rerun_addr", imem_addr, RST);
        idle(4, 1'b1);
        @(negedge clock);
        model_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle MIPS core. Holds the program counter, issues one instruction-memory read per instruction over a req/ready handshake, and latches the returned word for decode. It advances only on the single-cycle `step_pc` strobe produced by the upstream phase generator. `step_pc` is used as a clock enable, not as a clock. Branch and jump redirects are resolved here at that strobe.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- `clock`  in  1  single system clock; all state on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `step_pc`  in  1  one-cycle strobe from the phase generator; commit the current instruction and advance the PC
- `stall`  in  1  when 1, `step_pc` is ignored
- `jump`  in  1  select `jump_target` at the step
- `jump_target`  in  32  absolute jump address
- `branch_taken`  in  1  select `branch_target` at the step
- `branch_target`  in  32  absolute branch address
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  word address of the request; equals `pc`
- `imem_ready`  in  1  memory accepts the request and `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `pc`  out  32  address of the instruction being fetched or held
- `pc_plus4`  out  32  `pc` + 4, mod 2^32 (combinational)
- `instr`  out  32  latched instruction
- `instr_valid`  out  1  `instr` is valid for `pc`
- `step_miss`  out  1  sticky; set when a `step_pc` arrives before the instruction is valid
- `misaligned`  out  1  sticky; set when a selected redirect target has bits [1:0] ≠ 0

## Operation
- FSM with two states: FETCH and HOLD.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On a cycle with `imem_ready`=1: `instr`←`imem_rdata`, `instr_valid`←1, go to HOLD.
- HOLD:
  - `imem_req`=0; `instr` is stable.
  - On `step_pc`=1 and `stall`=0: `pc`←next PC, `instr_valid`←0, go to FETCH.
- Next-PC priority: `jump` > `branch_taken` > `pc_plus4`.
  - The selected target is written with bits [1:0] forced to 00.
  - If the raw target had bits [1:0] ≠ 00, `misaligned`←1.
- Wrap-around: `pc`=32'hFFFF_FFFC steps to 32'h0000_0000 with no flag.
- `step_pc` in FETCH, or coincident with `imem_ready` in FETCH:
  - The strobe is not honoured; PC unchanged; `step_miss`←1.
  - The word is still captured if `imem_ready`=1.
- `step_pc` with `stall`=1, in either state: ignored, no flag.
- `jump` and `branch_taken` are sampled only on an honoured step; ignored otherwise.
- Sticky flags clear only on reset.

## Timing
- Reset values, applied asynchronously while `reset_n`=0:
  - `pc`=`RESET_PC`
  - state=FETCH
  - `instr`=0
  - `instr_valid`=0, `step_miss`=0, `misaligned`=0
  - `imem_req`=0 while in reset
- First request: `imem_req`=1 is asserted in the first cycle after `reset_n` deasserts.
- Reset asserted mid-request: request drops immediately (asynchronously); no capture occurs.
- Fetch latency: `instr_valid` rises on the same posedge that samples `imem_ready`=1. With zero-wait memory, that is 1 cycle after request assertion.
- `imem_req` falls on that same edge. Each request is accepted exactly once.
- Step-to-request: `step_pc` honoured at edge N → `pc` updated and `imem_req`=1 in cycle N+1.
- Throughput: a 4-cycle phase period with a 1-cycle memory completes one instruction per period.

## Test plan
- Reset `RESET_PC`=32'h0000_0100, memory returns 32'h2008_0005 with zero wait:
  - `imem_req`=1 and `imem_addr`=0x100 in the first cycle after `reset_n` rises.
  - Next cycle: `instr`=0x2008_0005, `instr_valid`=1, `imem_req`=0.
- Sequential run: four honoured `step_pc` strobes from 0x100 with zero-wait memory → `pc` sequence 0x104, 0x108, 0x10C, 0x110; exactly one request per step.
- Redirects at one step: `jump`=1 (`jump_target`=0x400) and `branch_taken`=1 (`branch_target`=0x200) → `pc`=0x400.
  - Next step with `branch_taken`=1, `branch_target`=0x203 → `pc`=0x200, `misaligned`=1.
- Slow memory with `imem_ready` delayed 3 cycles; `step_pc` pulsed in FETCH:
  - `pc` unchanged; `step_miss`=1.
  - Instruction still captured when `imem_ready` rises.
  - `stall`=1 with `step_pc` in HOLD → no change, no flag.
- Wrap: force `pc` to 0xFFFF_FFFC via `jump`, then step → `pc`=0x0, `imem_addr`=0x0, no flags.
- Drop `reset_n` in a FETCH cycle while `imem_ready`=0:
  - Outputs immediately equal the reset values.
  - A new request to `RESET_PC` follows release.
